// File: rtl/alu_mem_seq_pkg.sv
// Shared definitions for the alu_mem_seq command sequencer: command encodings,
// FSM state encoding, ALU function codes and small decode helpers.
package alu_mem_seq_pkg;

  typedef enum logic [1:0] {
    CMD_REG  = 2'd0,  // ALU result -> register file
    CMD_MEM  = 2'd1,  // ALU result -> RAM
    CMD_LOAD = 2'd2,  // RAM word -> register file
    CMD_RSVD = 2'd3   // reserved, completes with err
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_NOR = 3'd3;
  localparam logic [2:0] ALU_ADD = 3'd4;
  localparam logic [2:0] ALU_SUB = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;
  localparam logic [2:0] ALU_SLL = 3'd7;

  localparam int LAT_W = 3;

  // Commands whose result targets the register file.
  function automatic logic cmd_writes_reg(input logic [1:0] op);
    return (op == CMD_REG) || (op == CMD_LOAD);
  endfunction

  // Commands that use the ALU result and are therefore subject to overflow.
  function automatic logic cmd_uses_alu(input logic [1:0] op);
    return (op == CMD_REG) || (op == CMD_MEM);
  endfunction

endpackage

// File: rtl/alu_mem_seq_lat_cnt.sv
// RAM read latency down-counter: loads a start value, decrements while
// enabled and flags when it has reached zero.
module alu_mem_seq_lat_cnt
  import alu_mem_seq_pkg::*;
#(
  parameter int W = LAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority over decrement; the counter saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/alu_mem_seq.sv
// alu_mem_seq: sequences one REG / MEM / LOAD command at a time through
// IDLE -> FETCH -> EXEC -> WB -> DONE, driving register-file and RAM control.
// All outputs are registered.
// Optional feature: define ALU_MEM_SEQ_OVF_TRAP_EN to suppress the write-back
// strobe of REG/MEM commands that overflowed and report err instead.
module alu_mem_seq
  import alu_mem_seq_pkg::*;
#(
  parameter int RAM_RD_LAT = 1
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       start,
  input  logic [1:0] cmd_op,
  input  logic [2:0] alu_op,
  input  logic [4:0] ra,
  input  logic [4:0] rb,
  input  logic [4:0] rw,
  input  logic [5:0] mem_addr,
  input  logic       OF,
  input  logic       ZF,
  output logic [4:0] R_Addr_A,
  output logic [4:0] R_Addr_B,
  output logic [4:0] W_Addr,
  output logic       Write_Reg,
  output logic [2:0] ALU_OP,
  output logic       Mem_Write,
  output logic [5:0] Mem_Addr,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       zf_q,
  output logic       of_q
);

`ifdef ALU_MEM_SEQ_OVF_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  // FETCH lasts RAM_RD_LAT cycles: the counter starts at RAM_RD_LAT-1 and
  // EXEC is entered from the FETCH cycle in which it reads zero.
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RAM_RD_LAT - 1);

  state_e     state;
  logic [1:0] cmd_l;
  logic [2:0] alu_l;
  logic [4:0] ra_l;
  logic [4:0] rb_l;
  logic [4:0] rw_l;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic ovf_trap_exec;
  logic ovf_trap_wb;
  logic wr_reg_next;
  logic wr_mem_next;
  logic err_next;

  alu_mem_seq_lat_cnt #(.W(LAT_W)) lat_cnt (
    .clk      (clk),
    .rst      (Reset),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Decode of counter control, write strobes and completion error.
  always_comb begin
    cnt_load      = (state == ST_IDLE) && start;
    cnt_dec       = (state == ST_FETCH);
    // In EXEC the flag is still the live OF input; by WB it sits in of_q.
    ovf_trap_exec = TRAP_EN && OF && cmd_uses_alu(cmd_l);
    ovf_trap_wb   = TRAP_EN && of_q && cmd_uses_alu(cmd_l);
    wr_reg_next   = cmd_writes_reg(cmd_l) && !ovf_trap_exec;
    wr_mem_next   = (cmd_l == CMD_MEM) && !ovf_trap_exec;
    err_next      = (cmd_l == CMD_RSVD) || ovf_trap_wb;
  end

  // Command FSM with all outputs registered; strobes and done are one-cycle.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      cmd_l     <= 2'd0;
      alu_l     <= 3'd0;
      ra_l      <= 5'd0;
      rb_l      <= 5'd0;
      rw_l      <= 5'd0;
      R_Addr_A  <= 5'd0;
      R_Addr_B  <= 5'd0;
      W_Addr    <= 5'd0;
      Write_Reg <= 1'b0;
      ALU_OP    <= 3'd0;
      Mem_Write <= 1'b0;
      Mem_Addr  <= 6'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      zf_q      <= 1'b0;
      of_q      <= 1'b0;
    end else begin
      Write_Reg <= 1'b0;
      Mem_Write <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cmd_l    <= cmd_op;
            alu_l    <= alu_op;
            ra_l     <= ra;
            rb_l     <= rb;
            rw_l     <= rw;
            Mem_Addr <= mem_addr;
            busy     <= 1'b1;
            err      <= 1'b0;
            state    <= ST_FETCH;
          end else begin
            state    <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (cnt_zero) begin
            ALU_OP   <= alu_l;
            R_Addr_A <= ra_l;
            R_Addr_B <= rb_l;
            state    <= ST_EXEC;
          end else begin
            state    <= ST_FETCH;
          end
        end
        ST_EXEC: begin
          zf_q      <= (cmd_l == CMD_LOAD) ? 1'b0 : ZF;
          of_q      <= (cmd_l == CMD_LOAD) ? 1'b0 : OF;
          Write_Reg <= wr_reg_next;
          Mem_Write <= wr_mem_next;
          if (wr_reg_next) begin
            W_Addr  <= rw_l;
          end else begin
            W_Addr  <= W_Addr;
          end
          state     <= ST_WB;
        end
        ST_WB: begin
          done  <= 1'b1;
          err   <= err_next;
          state <= ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mem_seq.sv
// Self-checking bench for alu_mem_seq: directed and random commands compared
// against a timeline model derived from the command rules. Honours
// ALU_MEM_SEQ_OVF_TRAP_EN when it is defined for the build.
module tb_alu_mem_seq;

  localparam int LAT = 2;
  localparam int P   = LAT + 4;  // cycles per command, accept to accept

`ifdef ALU_MEM_SEQ_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [2:0] alu_op = 3'd0;
  logic [4:0] ra = 5'd0, rb = 5'd0, rw = 5'd0;
  logic [5:0] mem_addr = 6'd0;
  logic       OF = 1'b0, ZF = 1'b0;
  logic [4:0] R_Addr_A, R_Addr_B, W_Addr;
  logic       Write_Reg, Mem_Write, busy, done, err, zf_q, of_q;
  logic [2:0] ALU_OP;
  logic [5:0] Mem_Addr;

  int checks = 0;
  int failures = 0;

  alu_mem_seq #(.RAM_RD_LAT(LAT)) dut (
    .clk(clk), .Reset(Reset), .start(start), .cmd_op(cmd_op), .alu_op(alu_op),
    .ra(ra), .rb(rb), .rw(rw), .mem_addr(mem_addr), .OF(OF), .ZF(ZF),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr),
    .Write_Reg(Write_Reg), .ALU_OP(ALU_OP), .Mem_Write(Mem_Write),
    .Mem_Addr(Mem_Addr), .busy(busy), .done(done), .err(err),
    .zf_q(zf_q), .of_q(of_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({R_Addr_A, R_Addr_B, W_Addr, Write_Reg, ALU_OP, Mem_Write,
                Mem_Addr, busy, done, err, zf_q, of_q});
  endfunction

  // Reference rules for one command.
  function automatic bit blocked(input logic [1:0] op, input logic ofl);
    return TRAP && ofl && (op == 2'd0 || op == 2'd1);
  endfunction

  // Issue one command and check it cycle by cycle. Cycle k is the k-th cycle
  // after the accepting edge: FETCH 1..LAT, EXEC LAT+1, WB LAT+2, DONE LAT+3.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] f, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] w, input logic [5:0] ma,
                         input logic zf, input logic ofl, input bit poke);
    bit exp_wreg, exp_mw, exp_err;
    exp_wreg = (op == 2'd0 || op == 2'd2) && !blocked(op, ofl);
    exp_mw   = (op == 2'd1) && !blocked(op, ofl);
    exp_err  = (op == 2'd3) || blocked(op, ofl);
    @(negedge clk);
    cmd_op = op; alu_op = f; ra = a; rb = b; rw = w; mem_addr = ma;
    ZF = zf; OF = ofl; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble command inputs: the latched copies must be used.
    cmd_op = 2'($urandom_range(3, 0)); alu_op = 3'($urandom_range(7, 0));
    ra = 5'($urandom_range(31, 0)); rb = 5'($urandom_range(31, 0));
    rw = 5'($urandom_range(31, 0)); mem_addr = 6'($urandom_range(63, 0));
    for (int k = 1; k <= P; k++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'(k <= LAT + 3));
      chk("done", 32'(done), 32'(k == LAT + 3));
      if (k == 1) chk("mem_addr_fetch", 32'(Mem_Addr), 32'(ma));
      if (k == LAT + 1) begin
        chk("alu_op_exec", 32'(ALU_OP), 32'(f));
        chk("r_addr_a", 32'(R_Addr_A), 32'(a));
        chk("r_addr_b", 32'(R_Addr_B), 32'(b));
      end
      if (k == LAT + 2) begin
        chk("write_reg_wb", 32'(Write_Reg), 32'(exp_wreg));
        chk("mem_write_wb", 32'(Mem_Write), 32'(exp_mw));
        chk("mem_addr_wb", 32'(Mem_Addr), 32'(ma));
        if (exp_wreg) chk("w_addr_wb", 32'(W_Addr), 32'(w));
      end else begin
        chk("strobe_outside_wb", 32'({Write_Reg, Mem_Write}), 32'd0);
      end
      if (k == LAT + 3) begin
        chk("err_done", 32'(err), 32'(exp_err));
        chk("zf_q", 32'(zf_q), 32'((op == 2'd2) ? 1'b0 : zf));
        chk("of_q", 32'(of_q), 32'((op == 2'd2) ? 1'b0 : ofl));
      end
      if (k == P) begin
        chk("err_held", 32'(err), 32'(exp_err));
        chk("alu_op_held", 32'(ALU_OP), 32'(f));
      end
      if (poke && k == 2) start = 1'b1;
      if (poke && k == 3) start = 1'b0;
    end
  endtask

  initial begin
    int dones[$];
    // Reset state.
    #1 Reset = 1'b1;
    #2 chk("reset_outputs", all_outputs(), 32'd0);
    @(negedge clk); @(negedge clk);
    Reset = 1'b0;

    // REG add 5+7 into r3.
    run_cmd(2'd0, 3'd4, 5'd1, 5'd2, 5'd3, 6'd0, 1'b0, 1'b0, 1'b0);
    // LOAD word 5 into r4.
    run_cmd(2'd2, 3'd0, 5'd0, 5'd0, 5'd4, 6'h05, 1'b1, 1'b1, 1'b0);
    // MEM add with overflow.
    run_cmd(2'd1, 3'd4, 5'd6, 5'd7, 5'd8, 6'h2a, 1'b0, 1'b1, 1'b0);
    // REG with overflow.
    run_cmd(2'd0, 3'd5, 5'd9, 5'd10, 5'd11, 6'h11, 1'b0, 1'b1, 1'b0);
    // Reserved command with start pulsed while busy.
    run_cmd(2'd3, 3'd2, 5'd12, 5'd13, 5'd14, 6'h3f, 1'b1, 1'b0, 1'b1);
    // REG with ZF set and a start poke.
    run_cmd(2'd0, 3'd0, 5'd31, 5'd30, 5'd29, 6'h01, 1'b1, 1'b0, 1'b1);

    // Random commands.
    for (int i = 0; i < 24; i++) begin
      run_cmd(2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)),
              5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)),
              5'($urandom_range(31, 0)), 6'($urandom_range(63, 0)),
              1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
              1'($urandom_range(1, 0)));
    end

    // start held for three commands: done pulses every P cycles.
    @(negedge clk);
    cmd_op = 2'd0; alu_op = 3'd4; ra = 5'd1; rb = 5'd2; rw = 5'd3;
    mem_addr = 6'd0; ZF = 1'b0; OF = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 3 * P + 2; c++) begin
      @(negedge clk);
      if (done) dones.push_back(c);
      if (c == 2 * P + 1) start = 1'b0;
    end
    chk("b2b_done_count", 32'(dones.size()), 32'd3);
    for (int i = 0; i < dones.size() && i < 3; i++) begin
      chk("b2b_done_cycle", 32'(dones[i]), 32'(i * P + LAT + 3));
    end

    // Reset asserted during WB aborts the command.
    @(negedge clk);
    cmd_op = 2'd0; rw = 5'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    chk("wb_before_reset", 32'(Write_Reg), 32'd1);
    #1 Reset = 1'b1;
    #1 chk("reset_in_wb_outputs", all_outputs(), 32'd0);
    @(negedge clk);
    Reset = 1'b0;
    for (int c = 1; c <= P; c++) begin
      @(negedge clk);
      chk("after_abort_quiet", 32'({done, busy, Write_Reg, Mem_Write}), 32'd0);
    end
    // First accept after reset release.
    start = 1'b1;
    @(negedge clk);
    chk("accept_after_reset", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (P) @(negedge clk);
    chk("idle_after_cmd", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mem_seq.md
ALU_MEM_SEQ -- requirements
Module: alu_mem_seq

Interface
REQ-001 The block SHALL have parameter RAM_RD_LAT, default 1, meaning RAM read latency in cycles, legal range 1..7.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: command request, sampled only in IDLE.
REQ-005 The block SHALL have port cmd_op, input, 2 bits: 0=REG (F->reg), 1=MEM (F->RAM), 2=LOAD (RAM->reg), 3=reserved.
REQ-006 The block SHALL have port alu_op, input, 3 bits: ALU function for REG/MEM.
REQ-007 The block SHALL have ports ra, rb and rw, each input, 5 bits: read A, read B and write register addresses.
REQ-008 The block SHALL have port mem_addr, input, 6 bits: RAM word address.
REQ-009 The block SHALL have ports OF and ZF, each input, 1 bit: ALU flags from the datapath.
REQ-010 The block SHALL have ports R_Addr_A, R_Addr_B and W_Addr, each output, 5 bits: register file addresses.
REQ-011 The block SHALL have port Write_Reg, output, 1 bit: register file write strobe.
REQ-012 The block SHALL have port ALU_OP, output, 3 bits: ALU function select.
REQ-013 The block SHALL have port Mem_Write, output, 1 bit: RAM write enable; port Mem_Addr, output, 6 bits: RAM address.
REQ-014 The block SHALL have ports busy, done and err, each output, 1 bit: busy = not IDLE; done = one-cycle completion pulse; err = error flag for the completing command.
REQ-015 The block SHALL have ports zf_q and of_q, each output, 1 bit: flags latched in EXEC.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, EXEC, WB and DONE; every command SHALL follow IDLE->FETCH->EXEC->WB->DONE->IDLE.
- IDLE, start=1: latch cmd_op, alu_op, ra, rb, rw, mem_addr -> FETCH.
- start outside IDLE: ignored, no queuing.
REQ-017 FETCH SHALL last exactly RAM_RD_LAT cycles via a down-counter; Mem_Addr = latched mem_addr from FETCH through WB.
REQ-018 EXEC SHALL last 1 cycle with ALU_OP = latched alu_op and R_Addr_A/B = ra/rb; at its end, zf_q/of_q SHALL capture ZF/OF (LOAD: both captured as 0).
REQ-019 WB SHALL last 1 cycle and drive exactly one strobe:
- REG: Write_Reg=1, W_Addr=rw.
- MEM: Mem_Write=1.
- LOAD: Write_Reg=1, W_Addr=rw.
- reserved: no strobe, err=1.
REQ-020 DONE SHALL assert done=1 for exactly 1 cycle; err SHALL be valid in that cycle and held until the next accept.
REQ-021 Latency: with start accepted at edge 0, done SHALL be high in cycle RAM_RD_LAT+3; back-to-back throughput SHALL be one command per RAM_RD_LAT+4 cycles.
REQ-022 Write_Reg and Mem_Write SHALL never be asserted outside WB and never together.
REQ-023 start=1 held continuously SHALL re-accept in the first IDLE cycle after DONE.
REQ-024 Outside WB, ALU_OP and address outputs SHALL hold their last driven values.

Reset
REQ-025 Reset=1 SHALL force IDLE asynchronously and set every output and latched field to 0, including mid-command; no write strobe SHALL be issued for an aborted command.
REQ-026 The first accept after reset release SHALL occur on the first rising edge with Reset=0 and start=1.

Configuration
REQ-027 With macro ALU_MEM_SEQ_OVF_TRAP_EN defined, REG/MEM commands with of_q=1 SHALL suppress the WB strobe and report err=1 in DONE.
REQ-028 Without ALU_MEM_SEQ_OVF_TRAP_EN, overflow SHALL not affect writes, and err SHALL report only reserved cmd_op.

Structure
REQ-029 The shared package SHALL hold the cmd_op encodings (CMD_REG, CMD_MEM, CMD_LOAD, CMD_RSVD), the FSM state encoding and the ALU_OP codes 0..7 (and, or, xor, nor, add, sub, slt, sll).
REQ-030 The latency counter SHALL be the single sub-module, lat_cnt: load, decrement, zero flag.

Verification
REQ-031 Reset; REG add, ra=1 (5), rb=2 (7), rw=3 -> done at cycle 4, Write_Reg=1 only in cycle 3 with W_Addr=3, zf_q=0, of_q=0.
REQ-032 LOAD mem_addr=6'h05, rw=4, RAM_RD_LAT=2 -> done at cycle 5, Write_Reg=1 with W_Addr=4 in cycle 4, Mem_Write=0 throughout.
REQ-033 MEM with A=32'h7FFF_FFFF, alu add, OF=1 -> with the macro: no Mem_Write, err=1; without it: Mem_Write=1, err=0.
REQ-034 cmd_op=3 -> no strobes, done with err=1; start pulsed during busy -> ignored, exactly one done.
REQ-035 Reset asserted in WB -> strobes drop immediately, state=IDLE, no done pulse, all outputs 0.
REQ-036 start held high for 3 commands -> done pulses spaced RAM_RD_LAT+4 cycles apart.
